// File: rtl/lmfe_pkg.sv
// lmfe_pkg: shared frame geometry and feeder FSM encoding for the LMFE pixel feeder.
package lmfe_pkg;
    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int PIX_W = 8;
    localparam int N_PIX = IMG_W * IMG_H;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/pf_skid_fifo.sv
// pf_skid_fifo: 2-entry skid FIFO; head is a register that keeps its last value once drained.
module pf_skid_fifo import lmfe_pkg::*; #(
    parameter int DW = PIX_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);
    logic [DW-1:0] tail;
    logic do_pop, do_push, load_head, load_tail;
    always_comb begin
        do_pop    = pop && (count != 2'd0);
        do_push   = push && (count != 2'd2 || do_pop);
        load_head = do_push && (count == 2'd0 || (count == 2'd1 && do_pop));
        load_tail = do_push && ((count == 2'd1 && !do_pop) || (count == 2'd2 && do_pop));
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= load_head ? din : (do_pop && count == 2'd2) ? tail : head;
            tail  <= load_tail ? din : tail;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/lmfe_pixel_feeder.sv
// lmfe_pixel_feeder: streams one frame from a synchronous image memory into LMFE, obeying busy,
// with a 2-entry skid FIFO hiding the one-cycle read latency.
module lmfe_pixel_feeder #(
    parameter int IMG_W = lmfe_pkg::IMG_W,
    parameter int IMG_H = lmfe_pkg::IMG_H,
    parameter int DW    = lmfe_pkg::PIX_W,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          img_rd,
    output logic [AW-1:0] img_addr,
    input  logic [DW-1:0] img_q,
    input  logic          busy,
    output logic          in_en,
    output logic [DW-1:0] Din,
    output logic          feeding,
    output logic          done
);
    import lmfe_pkg::*;
    localparam logic [AW:0] NPIX  = (AW+1)'(IMG_W * IMG_H);
    localparam logic [AW:0] LASTP = NPIX - 1'b1;
    state_t      state;
    logic [AW:0] rd_cnt, tx_cnt;
    logic [1:0]  count;
    logic [2:0]  occ;
    logic        inflight, xfer, go;
    pf_skid_fifo #(.DW(DW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .din   (img_q),
        .pop   (xfer),
        .head  (Din),
        .count (count)
    );
    // a pop at this edge frees a slot, so a full pipeline can still issue and sustain 1 pixel/cycle
    always_comb begin
        in_en    = count != 2'd0;
        xfer     = in_en && !busy;
        go       = state == IDLE && start;
        occ      = {1'b0, count} + {2'b0, inflight};
        img_rd   = state == RUN && rd_cnt < NPIX && (occ < 3'd2 || (xfer && occ == 3'd2));
        img_addr = rd_cnt[AW-1:0];
        feeding  = state == RUN || state == DRAIN;
        done     = state == DONE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            tx_cnt   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= img_rd;
            rd_cnt   <= go ? '0 : rd_cnt + (AW+1)'(img_rd);
            tx_cnt   <= go ? '0 : tx_cnt + (AW+1)'(xfer);
            case (state)
                IDLE:    state <= start ? RUN : IDLE;
                RUN:     state <= rd_cnt == NPIX ? DRAIN : RUN;
                DRAIN:   state <= (xfer && tx_cnt == LASTP) ? DONE : DRAIN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lmfe_pixel_feeder.sv
// tb_lmfe_pixel_feeder: scoreboard bench for the pixel feeder on a 32x32 frame, plus cycle-exact
// vector table for the first frame and hand-written corner sequences.
`timescale 1ns/1ps
module tb_lmfe_pixel_feeder;
    localparam int W = 32, H = 32, DW = 8, AW = 10, N = W * H;
    typedef struct {
        int cyc;
        int rd;
        int addr;
        int en;
        int din;
        int feed;
        int dn;
    } vec_t;

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0, busy = 1'b0;
    logic [DW-1:0] img_q = '0;
    logic [DW-1:0] Din;
    logic          img_rd, in_en, feeding, done;
    logic [AW-1:0] img_addr;
    int n_chk = 0, n_fail = 0, n_rd = 0, n_done = 0, n_xfer = 0;
    int occ = 0, infl = 0, pat = 0, busy_mode = 0, x0 = 0, d0 = 0, r0 = 0, e0 = 0, v0 = 0;
    int sb[$];
    vec_t vt[9];

    lmfe_pixel_feeder #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .img_rd(img_rd), .img_addr(img_addr),
        .img_q(img_q), .busy(busy), .in_en(in_en), .Din(Din), .feeding(feeding), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int pix(int a);
        return pat == 0 ? (a & 255) : ((a * 37 + (a >> 4) + 90) & 255);
    endfunction

    always @(posedge clk) if (img_rd) img_q <= DW'(pix(int'(img_addr)));

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // one cycle: drive busy at the negedge, sample settled outputs 1 ns later, update model
    task automatic step();
        bit x;
        @(negedge clk);
        busy = busy_mode == 2 ? 1'b1 : busy_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
        #1;
        x = in_en && !busy;
        if (img_rd) begin
            n_rd++;
            chk("read_would_overflow", (occ + infl - int'(x) <= 1) ? 1 : 0, 1);
        end
        chk("in_en_vs_occupancy", int'(in_en), int'(occ != 0));
        if (done) n_done++;
        if (x) begin
            n_xfer++;
            if (sb.size() == 0) chk("unexpected_beat", int'(Din), -1);
            else chk("din_order", int'(Din), sb.pop_front());
        end
        occ  = occ + infl - int'(x);
        infl = int'(img_rd);
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_img_rd"}, int'(img_rd), 0);
        chk({nm, "_img_addr"}, int'(img_addr), 0);
        chk({nm, "_in_en"}, int'(in_en), 0);
        chk({nm, "_Din"}, int'(Din), 0);
        chk({nm, "_feeding"}, int'(feeding), 0);
        chk({nm, "_done"}, int'(done), 0);
    endtask

    task automatic start_frame();
        for (int i = 0; i < N; i++) sb.push_back(pix(i));
        x0 = n_xfer;
        d0 = n_done;
        r0 = n_rd;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic frame_tail();
        chk("frame_beats", n_xfer - x0, N);
        chk("frame_done_pulses", n_done - d0, 1);
        chk("frame_sb_empty", sb.size(), 0);
    endtask

    task automatic wait_done(int budget);
        int k = 0;
        while (!done && k < budget) begin
            step();
            k++;
        end
        chk("done_seen", int'(done), 1);
        frame_tail();
    endtask

    task automatic run_to_beat(int b);
        int k = 0;
        while (n_xfer - x0 < b && k < 8 * N) begin
            step();
            k++;
        end
        chk("reach_beat", n_xfer - x0, b);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #0.5;
        chk_zero("async_reset");
        #0.5;
        reset = 1'b1;
        sb.delete();
        occ  = 0;
        infl = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vt = '{'{1, 1, 0, 0, 0, 1, 0},
               '{2, 1, 1, 0, 0, 1, 0},
               '{3, 1, 2, 1, 0, 1, 0},
               '{4, 1, 3, 1, 1, 1, 0},
               '{N, 1, N - 1, 1, (N - 3) % 256, 1, 0},
               '{N + 1, 0, -1, 1, (N - 2) % 256, 1, 0},
               '{N + 2, 0, -1, 1, (N - 1) % 256, 1, 0},
               '{N + 3, 0, -1, 0, (N - 1) % 256, 0, 1},
               '{N + 4, 0, -1, 0, (N - 1) % 256, 0, 0}};
        repeat (3) @(negedge clk);
        #1;
        chk_zero("in_reset");
        reset = 1'b1;
        step();
        chk_zero("after_reset");

        // T1: cycle-exact latency and throughput, mem[a] = a[7:0]
        pat = 0;
        start_frame();
        for (int c = 1; c <= N + 4; c++) begin
            if (c > 1) step();
            foreach (vt[i]) if (vt[i].cyc == c) begin
                chk("t1_img_rd", int'(img_rd), vt[i].rd);
                if (vt[i].addr >= 0) chk("t1_img_addr", int'(img_addr), vt[i].addr);
                chk("t1_in_en", int'(in_en), vt[i].en);
                chk("t1_Din", int'(Din), vt[i].din);
                chk("t1_feeding", int'(feeding), vt[i].feed);
                chk("t1_done", int'(done), vt[i].dn);
            end
        end
        frame_tail();

        // T2: busy on ~3 of 4 cycles
        pat = 1;
        busy_mode = 1;
        start_frame();
        wait_done(20 * N);
        busy_mode = 0;
        step();
        chk("t2_done_single", int'(done), 0);

        // T3: 100-cycle stall from beat 500
        start_frame();
        run_to_beat(500);
        busy_mode = 2;
        for (int i = 0; i < 100; i++) begin
            step();
            if (i == 0) begin
                e0 = int'(in_en);
                v0 = int'(Din);
                chk("t3_in_en_held", e0, 1);
            end else begin
                chk("t3_in_en_stable", int'(in_en), e0);
                chk("t3_Din_stable", int'(Din), v0);
            end
            if (i >= 2) chk("t3_no_read", int'(img_rd), 0);
        end
        busy_mode = 0;
        step();
        chk("t3_resume_pixel", int'(Din), pix(500));
        wait_done(4 * N);
        step();

        // T4: asynchronous reset mid-frame, then a clean frame from pixel 0
        start_frame();
        run_to_beat(300);
        reset_pulse();
        step();
        chk_zero("t4_after");
        start_frame();
        chk("t4_restart_addr0", int'(img_addr), 0);
        wait_done(4 * N);
        step();

        // T5: start during RUN and during the done cycle is ignored
        start_frame();
        repeat (100) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(4 * N);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_no_restart_feeding", int'(feeding), 0);
        chk("t5_no_restart_rd", int'(img_rd), 0);
        chk("t5_done_cleared", int'(done), 0);
        start_frame();
        chk("t5_fresh_feeding", int'(feeding), 1);
        chk("t5_fresh_rd", int'(img_rd), 1);
        chk("t5_fresh_addr0", int'(img_addr), 0);
        wait_done(4 * N);
        step();

        // T6: busy held from reset through start
        busy_mode = 2;
        step();
        reset_pulse();
        step();
        start_frame();
        repeat (50) step();
        chk("t6_reads", n_rd - r0, 2);
        chk("t6_in_en", int'(in_en), 1);
        chk("t6_Din", int'(Din), pix(0));
        chk("t6_stalled_rd", int'(img_rd), 0);
        busy_mode = 0;
        wait_done(4 * N);
        step();
        chk("t6_done_single", int'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
